dmem_arbiter: RTL and testbench

//  Two-port arbiter/sequencer in front of the single-port DataMem (1-cycle registered read).

---
 rtl/dmem_arbiter_pkg.sv | 43 ++++
 rtl/dmem_arbiter_if.sv | 70 +++++++
 rtl/dmem_arb_starve.sv | 46 ++++
 rtl/dmem_arbiter.sv | 158 +++++++++++++++
 tb/tb_dmem_arbiter.sv | 298 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// dmem_arbiter_pkg
// Shared definitions for the two-port data-memory arbiter:
//   - default word width for data and address buses
//   - width of the port-1 starvation counter
//   - arbiter FSM state encoding (FREE / LOCK1)
//   - read-return owner ids (PORT0 / PORT1)
//   - saturating next-value helper for the starvation counter
// ---------------------------------------------------------------------------
package dmem_arbiter_pkg;

    localparam int WORD_W       = 32;
    localparam int STARVE_CNT_W = 4;

    typedef enum logic {
        ARB_FREE  = 1'b0,
        ARB_LOCK1 = 1'b1
    } arb_state_e;

    typedef enum logic {
        ARB_PORT0 = 1'b0,
        ARB_PORT1 = 1'b1
    } arb_port_e;

    // Next value of the starvation counter: counts up while port 1 is
    // starved and sticks at the threshold; any non-starved cycle clears it.
    function automatic logic [STARVE_CNT_W-1:0] starve_next(
        input logic [STARVE_CNT_W-1:0] cnt,
        input logic [STARVE_CNT_W-1:0] max,
        input logic                    starved
    );
        logic [STARVE_CNT_W-1:0] nxt;
        if (!starved) begin
            nxt = '0;
        end else if (cnt >= max) begin
            nxt = max;
        end else begin
            nxt = cnt + 1'b1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// ---------------------------------------------------------------------------
// dmem_arbiter_if / dmem_mem_if
// Bus bundles used by the data-memory arbiter.
//
// dmem_arbiter_if : one requester port (core LSU or loader/debug DMA)
//   req    requester -> arbiter  access request, held until granted
//   we     requester -> arbiter  write (1) / read (0)
//   addr   requester -> arbiter  word address
//   wdata  requester -> arbiter  write data
//   gnt    arbiter -> requester  access accepted this cycle (combinational)
//   rvalid arbiter -> requester  read data valid (one cycle after grant)
//   rdata  arbiter -> requester  read data, zero when rvalid is low
//   modports: master (requester side), slave (arbiter side)
//
// dmem_mem_if : single-port DataMem with 1-cycle registered read
//   we/re/addr/wdata  arbiter -> memory
//   rdata             memory -> arbiter
//   modports: master (arbiter side), slave (memory side)
// ---------------------------------------------------------------------------
interface dmem_arbiter_if
    import dmem_arbiter_pkg::*;
#(
    parameter int DATA_W = WORD_W,
    parameter int ADDR_W = WORD_W
) ();

    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              gnt;
    logic              rvalid;
    logic [DATA_W-1:0] rdata;

    modport master (
        output req, we, addr, wdata,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, we, addr, wdata,
        output gnt, rvalid, rdata
    );

endinterface

interface dmem_mem_if
    import dmem_arbiter_pkg::*;
#(
    parameter int DATA_W = WORD_W,
    parameter int ADDR_W = WORD_W
) ();

    logic              we;
    logic              re;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;

    modport master (
        output we, re, addr, wdata,
        input  rdata
    );

    modport slave (
        input  we, re, addr, wdata,
        output rdata
    );

endinterface

// File: rtl/dmem_arb_starve.sv
// ---------------------------------------------------------------------------
// dmem_arb_starve
// Port-1 starvation tracker. Counts consecutive cycles in which port 1 is
// requesting but not granted, saturating at STARVE_MAX, and flags when the
// threshold is reached so the arbiter can force a port-1 grant.
//
// Ports:
//   clk_i   in   clock, all state on posedge
//   rst_ni  in   synchronous reset, active-low
//   req_i   in   port 1 request
//   gnt_i   in   port 1 grant (this cycle)
//   hit_o   out  counter has reached STARVE_MAX (registered)
// ---------------------------------------------------------------------------
module dmem_arb_starve
    import dmem_arbiter_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic req_i,
    input  logic gnt_i,
    output logic hit_o
);

    localparam logic [STARVE_CNT_W-1:0] MaxCnt = STARVE_CNT_W'(STARVE_MAX);

    logic [STARVE_CNT_W-1:0] cnt_q;
    logic [STARVE_CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = starve_next(cnt_q, MaxCnt, req_i & ~gnt_i);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Registered compare keeps the grant path free of the counter adder.
    assign hit_o = (cnt_q == MaxCnt);

endmodule

// File: rtl/dmem_arbiter.sv
// ---------------------------------------------------------------------------
// dmem_arbiter
// Two-port arbiter/sequencer in front of a single-port DataMem with a
// 1-cycle registered read. Port 0 is the core load/store unit, port 1 the
// loader/debug DMA. One access is granted per cycle, read data is routed
// back to the port that issued the read, port-1 starvation is bounded by
// STARVE_MAX, and port 1 may lock the memory across a burst.
//
// Parameters:
//   DATA_W      data word width
//   ADDR_W      address width
//   STARVE_MAX  max consecutive denied cycles for a requesting port 1 (1..15)
//
// Ports:
//   clk_i      in     clock, all state on posedge
//   rst_ni     in     synchronous reset, active-low
//   m0_if      slave  port 0 requester bundle (req/we/addr/wdata/gnt/rvalid/rdata)
//   m1_if      slave  port 1 requester bundle (same signals)
//   m1_lock_i  in     port 1 requests exclusive ownership while asserted
//   mem_if     master DataMem bundle (we/re/addr/wdata out, rdata in)
// ---------------------------------------------------------------------------
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int DATA_W     = WORD_W,
    parameter int ADDR_W     = WORD_W,
    parameter int STARVE_MAX = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    dmem_arbiter_if.slave         m0_if,
    dmem_arbiter_if.slave         m1_if,
    input  logic                  m1_lock_i,
    dmem_mem_if.master            mem_if
);

    arb_state_e state_q;
    arb_state_e state_d;

    logic       gnt0;
    logic       gnt1;
    logic       starve_hit;

    logic       rd_pend_q;
    logic       rd_pend_d;
    arb_port_e  rd_owner_q;
    arb_port_e  rd_owner_d;

    logic       rvalid0;
    logic       rvalid1;

    // ---------------------------------------------------------------------
    // Starvation tracking for port 1
    // ---------------------------------------------------------------------
    dmem_arb_starve #(
        .STARVE_MAX (STARVE_MAX)
    ) u_starve (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .req_i  (m1_if.req),
        .gnt_i  (gnt1),
        .hit_o  (starve_hit)
    );

    // ---------------------------------------------------------------------
    // FSM: state register
    // ---------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= ARB_FREE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------------------------------------------------------------
    // FSM: next state and grant decision
    // Grants are forced low during reset so nothing reaches memory while
    // the state registers still hold pre-reset values.
    // ---------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        gnt0    = 1'b0;
        gnt1    = 1'b0;

        if (rst_ni) begin
            unique case (state_q)
                ARB_FREE: begin
                    // Port 1 wins when port 0 is idle or when it has been
                    // denied STARVE_MAX cycles in a row; otherwise port 0.
                    if (m1_if.req && (!m0_if.req || starve_hit)) begin
                        gnt1 = 1'b1;
                    end else begin
                        gnt0 = m0_if.req;
                    end
                    if (gnt1 && m1_lock_i) begin
                        state_d = ARB_LOCK1;
                    end
                end
                ARB_LOCK1: begin
                    // Port 0 is shut out for the whole locked burst,
                    // including the cycle in which the lock drops.
                    gnt1 = m1_if.req;
                    if (!m1_lock_i) begin
                        state_d = ARB_FREE;
                    end
                end
                default: begin
                    state_d = ARB_FREE;
                end
            endcase
        end
    end

    assign m0_if.gnt = gnt0;
    assign m1_if.gnt = gnt1;

    // ---------------------------------------------------------------------
    // Memory drive: winner's request is muxed onto the memory port. With
    // no winner the address/data follow port 0 and are don't-care.
    // ---------------------------------------------------------------------
    always_comb begin
        mem_if.we    = (gnt0 &  m0_if.we) | (gnt1 &  m1_if.we);
        mem_if.re    = (gnt0 & ~m0_if.we) | (gnt1 & ~m1_if.we);
        mem_if.addr  = gnt1 ? m1_if.addr  : m0_if.addr;
        mem_if.wdata = gnt1 ? m1_if.wdata : m0_if.wdata;
    end

    // ---------------------------------------------------------------------
    // Read-return tracking: remember who issued the read so the memory's
    // registered data one cycle later can be steered to that port.
    // ---------------------------------------------------------------------
    always_comb begin
        rd_pend_d  = mem_if.re;
        rd_owner_d = gnt1 ? ARB_PORT1 : ARB_PORT0;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rd_pend_q  <= 1'b0;
            rd_owner_q <= ARB_PORT0;
        end else begin
            rd_pend_q  <= rd_pend_d;
            rd_owner_q <= rd_owner_d;
        end
    end

    // A read granted just before reset asserts must not surface as rvalid
    // during the reset cycle, hence the rst_ni qualification.
    assign rvalid0 = rst_ni & rd_pend_q & (rd_owner_q == ARB_PORT0);
    assign rvalid1 = rst_ni & rd_pend_q & (rd_owner_q == ARB_PORT1);

    assign m0_if.rvalid = rvalid0;
    assign m1_if.rvalid = rvalid1;
    assign m0_if.rdata  = rvalid0 ? mem_if.rdata : '0;
    assign m1_if.rdata  = rvalid1 ? mem_if.rdata : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

    localparam int DW         = 32;
    localparam int AW         = 32;
    localparam int STARVE_MAX = 4;

    logic clk;
    logic rst_ni;
    logic m1_lock;

    int checks = 0;
    int errors = 0;

    dmem_arbiter_if #(.DATA_W(DW), .ADDR_W(AW)) m0_if ();
    dmem_arbiter_if #(.DATA_W(DW), .ADDR_W(AW)) m1_if ();
    dmem_mem_if     #(.DATA_W(DW), .ADDR_W(AW)) mem_if ();

    dmem_arbiter #(
        .DATA_W     (DW),
        .ADDR_W     (AW),
        .STARVE_MAX (STARVE_MAX)
    ) dut (
        .clk_i     (clk),
        .rst_ni    (rst_ni),
        .m0_if     (m0_if),
        .m1_if     (m1_if),
        .m1_lock_i (m1_lock),
        .mem_if    (mem_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] init_val(input logic [7:0] a);
        return (a == 8'h05) ? 32'hDEADBEEF : {24'hA5A500, a};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // DataMem stand-in: 256 words, registered read, write on posedge.
    logic [31:0] dmem [256];
    initial begin
        for (int a = 0; a < 256; a++) dmem[a] = init_val(a[7:0]);
        mem_if.rdata = '0;
        forever begin
            @(posedge clk);
            if (mem_if.re) mem_if.rdata = dmem[mem_if.addr[7:0]];
            if (mem_if.we) dmem[mem_if.addr[7:0]] = mem_if.wdata;
        end
    end

    // Behavioural model: expected memory contents, expected read returns
    // in issue order, lock flag and denied-cycle count, checked each cycle.
    typedef struct {
        bit          owner;
        logic [31:0] data;
    } rd_t;

    rd_t         rq[$];
    logic [31:0] shadow [256];
    bit          m_locked;
    int          m_starve;
    rd_t         r;
    logic        w0, w1, ev0, ev1, wr;
    logic [31:0] ed0, ed1, wa;

    initial begin
        for (int a = 0; a < 256; a++) shadow[a] = init_val(a[7:0]);
        m_locked = 0;
        m_starve = 0;
        forever begin
            @(negedge clk);
            ev0 = 0; ev1 = 0; ed0 = '0; ed1 = '0;
            if (rq.size() != 0) begin
                r = rq.pop_front();
                if (r.owner) begin ev1 = 1; ed1 = r.data; end
                else         begin ev0 = 1; ed0 = r.data; end
            end
            if (!rst_ni) begin
                w0 = 0; w1 = 0; ev0 = 0; ev1 = 0; ed0 = '0; ed1 = '0;
                rq.delete();
                m_locked = 0;
                m_starve = 0;
            end else begin
                w1 = m1_if.req && (m_locked || !m0_if.req || m_starve == STARVE_MAX);
                w0 = !m_locked && m0_if.req && !w1;
            end
            chk("m_gnt0",   m0_if.gnt,    w0);
            chk("m_gnt1",   m1_if.gnt,    w1);
            chk("m_rv0",    m0_if.rvalid, ev0);
            chk("m_rv1",    m1_if.rvalid, ev1);
            chk("m_rd0",    m0_if.rdata,  ed0);
            chk("m_rd1",    m1_if.rdata,  ed1);
            wr = w1 ? m1_if.we : m0_if.we;
            chk("m_mem_we", mem_if.we, (w0 || w1) && wr);
            chk("m_mem_re", mem_if.re, (w0 || w1) && !wr);
            if (w0 || w1) begin
                wa = w1 ? m1_if.addr : m0_if.addr;
                chk("m_mem_addr", mem_if.addr, wa);
                if (wr) begin
                    chk("m_mem_wdata", mem_if.wdata, w1 ? m1_if.wdata : m0_if.wdata);
                    shadow[wa[7:0]] = w1 ? m1_if.wdata : m0_if.wdata;
                end else begin
                    rq.push_back('{owner: w1, data: shadow[wa[7:0]]});
                end
            end
            if (rst_ni) begin
                if (m1_if.req && !w1) m_starve = (m_starve < STARVE_MAX) ? m_starve + 1 : STARVE_MAX;
                else                  m_starve = 0;
                if (!m_locked && w1 && m1_lock) m_locked = 1;
                else if (m_locked && !m1_lock)  m_locked = 0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion, expected finish before %0t", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
        #1;
    endtask

    task automatic idle_all();
        m0_if.req = 0; m0_if.we = 0; m0_if.addr = '0; m0_if.wdata = '0;
        m1_if.req = 0; m1_if.we = 0; m1_if.addr = '0; m1_if.wdata = '0;
        m1_lock = 0;
    endtask

    logic [9:0] g0, g1;
    logic       got;
    int         n0;

    initial begin
        idle_all();
        rst_ni = 0;
        m0_if.req = 1;   // request under reset must not be granted
        sample();
        chk("rst_gnt0",   m0_if.gnt,    0);
        chk("rst_mem_re", mem_if.re,    0);
        chk("rst_rv0",    m0_if.rvalid, 0);
        tick();
        tick();
        rst_ni = 1;
        idle_all();

        // T1: m0 read of 0x05 alone
        tick();
        m0_if.req = 1; m0_if.we = 0; m0_if.addr = 32'h05;
        sample();
        chk("t1_gnt0", m0_if.gnt, 1);
        chk("t1_re",   mem_if.re, 1);
        tick();
        idle_all();
        sample();
        chk("t1_rv0",  m0_if.rvalid, 1);
        chk("t1_rd0",  m0_if.rdata,  32'hDEADBEEF);
        chk("t1_rv1",  m1_if.rvalid, 0);

        // T4: m0 write 0x1234 @0x08, read it back next cycle
        tick();
        m0_if.req = 1; m0_if.we = 1; m0_if.addr = 32'h08; m0_if.wdata = 32'h1234;
        sample();
        chk("t4_gnt_wr", m0_if.gnt, 1);
        chk("t4_we",     mem_if.we, 1);
        tick();
        m0_if.we = 0;
        sample();
        chk("t4_wr_no_rv", m0_if.rvalid, 0);
        tick();
        idle_all();
        sample();
        chk("t4_rv0", m0_if.rvalid, 1);
        chk("t4_rd0", m0_if.rdata,  32'h1234);

        // T2: both request continuously -> m1 every 5th cycle
        tick();
        m0_if.req = 1; m0_if.addr = 32'h01;
        m1_if.req = 1; m1_if.addr = 32'h02;
        for (int i = 0; i < 10; i++) begin
            sample();
            g0[i] = m0_if.gnt;
            g1[i] = m1_if.gnt;
            tick();
        end
        chk("t2_m1_pattern", {22'd0, g1}, 32'h210);
        chk("t2_m0_pattern", {22'd0, g0}, 32'h1EF);
        idle_all();

        // T3: m1 locked write burst 0x10..0x13 while m0 keeps requesting
        tick();
        m0_if.req = 1; m0_if.addr = 32'h03;
        m1_if.req = 1; m1_if.we = 1; m1_if.addr = 32'h10; m1_if.wdata = 32'h100;
        m1_lock = 1;
        got = 0; n0 = 0;
        for (int i = 0; i < 8 && !got; i++) begin
            sample();
            if (m1_if.gnt) got = 1;
            else begin
                if (m0_if.gnt) n0++;
                tick();
            end
        end
        chk("t3_first_beat", got, 1);
        chk("t3_m0_before",  n0,  4);
        for (int b = 1; b < 4; b++) begin
            tick();
            m1_if.addr = 32'h10 + b; m1_if.wdata = 32'h100 + b;
            sample();
            chk("t3_beat_gnt1", m1_if.gnt, 1);
            chk("t3_beat_gnt0", m0_if.gnt, 0);
        end
        tick();
        m1_if.req = 0; m1_if.we = 0; m1_lock = 0;
        sample();
        chk("t3_release_gnt0", m0_if.gnt, 0);
        tick();
        sample();
        chk("t3_after_gnt0", m0_if.gnt, 1);
        tick();
        idle_all();

        // T6: alternating single reads of the burst data
        tick();
        m0_if.req = 1; m0_if.addr = 32'h10;
        tick();
        m0_if.req = 0; m1_if.req = 1; m1_if.addr = 32'h11;
        sample();
        chk("t6_rv0_a", m0_if.rvalid, 1);
        chk("t6_rd0_a", m0_if.rdata,  32'h100);
        chk("t6_rd1_a", m1_if.rdata,  0);
        tick();
        m1_if.req = 0; m0_if.req = 1; m0_if.addr = 32'h12;
        sample();
        chk("t6_rv1_b", m1_if.rvalid, 1);
        chk("t6_rd1_b", m1_if.rdata,  32'h101);
        chk("t6_rv0_b", m0_if.rvalid, 0);
        tick();
        m0_if.req = 0; m1_if.req = 1; m1_if.addr = 32'h13;
        sample();
        chk("t6_rd0_c", m0_if.rdata, 32'h102);
        tick();
        idle_all();
        sample();
        chk("t6_rv1_d", m1_if.rvalid, 1);
        chk("t6_rd1_d", m1_if.rdata,  32'h103);

        // T5: reset right after a locked m1 read grant
        tick();
        m1_if.req = 1; m1_if.addr = 32'h05; m1_lock = 1;
        sample();
        chk("t5_gnt1", m1_if.gnt, 1);
        tick();
        rst_ni = 0; m1_if.req = 0;
        sample();
        chk("t5_rv1_rst", m1_if.rvalid, 0);
        chk("t5_rd1_rst", m1_if.rdata,  0);
        tick();
        rst_ni = 1; m1_lock = 0;
        m0_if.req = 1; m0_if.addr = 32'h01;
        m1_if.req = 1; m1_if.addr = 32'h02;
        sample();
        chk("t5_rv1_after", m1_if.rvalid, 0);
        got = 0; n0 = 0;
        for (int i = 0; i < 8 && !got; i++) begin
            if (i != 0) sample();
            if (m1_if.gnt) got = 1;
            else begin
                if (m0_if.gnt) n0++;
                tick();
            end
        end
        chk("t5_m1_eventually", got, 1);
        chk("t5_m0_before",     n0,  4);
        tick();
        idle_all();
        tick();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
